// File: rtl/pico_axi_mem_bridge.sv
// picorv32 native memory port to AXI4-lite master bridge with per-node address relocation.
// Optional bus watchdog (trap on stalled transfers) is built when PICO_BRIDGE_TIMEOUT_EN is defined.
module pico_axi_mem_bridge #(
    parameter int unsigned NODE_ID        = 0,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NODE_WINDOW    = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                res,

    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   mem_rdata,

    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,

    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,

    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,

    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,

    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,

    output logic                trap
);

    // Relocation offset wraps modulo 2^ADDR_W, never saturates.
    localparam logic [ADDR_W-1:0] NODE_OFFSET = ADDR_W'(64'(NODE_ID) * 64'(NODE_WINDOW));

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("pico_axi_mem_bridge: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("pico_axi_mem_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
`ifdef PICO_BRIDGE_TIMEOUT_EN
        , FAULT
`endif
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;

`ifdef PICO_BRIDGE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            progress;

    // Any handshake this cycle wins over the watchdog firing on the same edge.
    always_comb begin
        progress = 1'b0;
        case (state)
            RD_ADDR: progress = m_axi_arready;
            RD_DATA: progress = m_axi_rvalid;
            WR_REQ:  progress = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready);
            WR_RESP: progress = m_axi_bvalid;
            default: progress = 1'b0;
        endcase
    end

    assign wd_expire = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            mem_ready     <= 1'b0;
            mem_rdata     <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awprot  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arprot  <= '0;
            m_axi_rready  <= 1'b0;
`ifdef PICO_BRIDGE_TIMEOUT_EN
            wd_cnt        <= '0;
            trap          <= 1'b0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // The mem_ready cycle is skipped so a held mem_valid cannot replay the request.
                    if (mem_valid && !mem_ready) begin
                        if (|mem_wstrb) begin
                            m_axi_awaddr  <= mem_addr + NODE_OFFSET;
                            m_axi_awprot  <= {mem_instr, 2'b00};
                            m_axi_wdata   <= mem_wdata;
                            m_axi_wstrb   <= mem_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_araddr  <= mem_addr + NODE_OFFSET;
                            m_axi_arprot  <= {mem_instr, 2'b00};
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        mem_rdata    <= m_axi_rdata;
                        mem_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || (m_axi_awvalid && m_axi_awready)) &&
                        (w_done  || (m_axi_wvalid  && m_axi_wready))) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        mem_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                end
            endcase
`ifdef PICO_BRIDGE_TIMEOUT_EN
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (state != FAULT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                // Overrides the case above: abandon the transfer and park until reset.
                if (wd_expire && !progress) begin
                    m_axi_awvalid <= 1'b0;
                    m_axi_wvalid  <= 1'b0;
                    m_axi_bready  <= 1'b0;
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b0;
                    trap          <= 1'b1;
                    state         <= FAULT;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_pico_axi_mem_bridge.sv
// Self-checking bench for pico_axi_mem_bridge: table-driven read/write transactions against a
// bench-side AXI-lite slave with per-vector stall counts, plus reset and watchdog sequences.
module tb_pico_axi_mem_bridge;

    logic        clk;
    logic        res;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic        trap;

    int checks   = 0;
    int failures = 0;

    pico_axi_mem_bridge #(
        .NODE_ID        (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .NODE_WINDOW    (32'h0001_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .res           (res),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .trap          (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    typedef struct {
        bit          wr;
        bit          instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int unsigned d_a;       // AR or AW stall cycles
        int unsigned d_w;       // W stall cycles
        int unsigned d_r;       // R or B stall cycles after rready/bready
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [2:0]  exp_prot;
        int unsigned exp_lat;   // cycle of mem_ready, mem_valid seen in cycle 0
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_valids"}, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready,
                                 m_axi_bready, mem_ready, trap}), 64'(0));
        chk({p, "_araddr"}, 64'(m_axi_araddr), 64'(0));
        chk({p, "_awaddr"}, 64'(m_axi_awaddr), 64'(0));
        chk({p, "_wdata"},  64'({m_axi_wdata, m_axi_wstrb}), 64'(0));
        chk({p, "_prot"},   64'({m_axi_awprot, m_axi_arprot}), 64'(0));
        chk({p, "_rdata"},  64'(mem_rdata), 64'(0));
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 32'h0BAD_0BAD;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc = 0;
        int          ready_cnt = 0;
        int          ready_cyc = -1;
        int          ar_hs = 0, aw_hs = 0, w_hs = 0, extra = 0;
        int unsigned ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
        logic [31:0] hs_addr = '0, hs_wdata = '0, got_rdata = '0;
        logic [2:0]  hs_prot = '0;
        logic [3:0]  hs_wstrb = '0;
        bit          done = 0;
        string       p;
        p = $sformatf("v%0d", idx);

        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = v.instr;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        slave_idle();
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            m_axi_arready = m_axi_arvalid && (ar_wait == v.d_a);
            if (m_axi_arvalid) ar_wait++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs++;
                hs_addr = m_axi_araddr;
                hs_prot = m_axi_arprot;
            end
            m_axi_awready = m_axi_awvalid && (aw_wait == v.d_a);
            if (m_axi_awvalid) aw_wait++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs++;
                hs_addr = m_axi_awaddr;
                hs_prot = m_axi_awprot;
            end
            m_axi_wready = m_axi_wvalid && (w_wait == v.d_w);
            if (m_axi_wvalid) w_wait++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs++;
                hs_wdata = m_axi_wdata;
                hs_wstrb = m_axi_wstrb;
            end
            m_axi_rvalid = m_axi_rready && (r_wait == v.d_r);
            if (m_axi_rready) r_wait++;
            m_axi_rdata = m_axi_rvalid ? v.rdata : 32'h0BAD_0BAD;
            m_axi_bvalid = m_axi_bready && (b_wait == v.d_r);
            if (m_axi_bready) b_wait++;
            if (mem_ready) begin
                ready_cnt++;
                ready_cyc = cyc;
                got_rdata = mem_rdata;
                done      = 1;
            end
        end
        chk({p, "_completes"}, 64'(done), 64'(1));
        // mem_valid stays high through the mem_ready cycle, then drops; nothing further may start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            slave_idle();
            mem_valid = 1'b0;
            if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) extra++;
            if (mem_ready) ready_cnt++;
        end
        chk({p, "_addr"},      64'(hs_addr), 64'(v.exp_addr));
        chk({p, "_prot"},      64'(hs_prot), 64'(v.exp_prot));
        chk({p, "_ready_cnt"}, 64'(ready_cnt), 64'(1));
        chk({p, "_latency"},   64'(ready_cyc), 64'(v.exp_lat));
        chk({p, "_rdata"},     64'(got_rdata), 64'(v.exp_rdata));
        chk({p, "_ar_hs"},     64'(ar_hs), 64'(v.wr ? 0 : 1));
        chk({p, "_aw_w_hs"},   64'({aw_hs[7:0], w_hs[7:0]}), 64'(v.wr ? 16'h0101 : 16'h0000));
        chk({p, "_no_dup"},    64'(extra), 64'(0));
        if (v.wr) begin
            chk({p, "_wdata"}, 64'({hs_wdata, hs_wstrb}), 64'({v.wdata, v.wstrb}));
        end
    endtask

    initial begin
        // NODE_ID=2, NODE_WINDOW=0x10000 -> offset 0x0002_0000
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0,
                    32'hDEAD_BEEF, 32'h0002_0100, 3'b000, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'h0, 4'h0, 1, 0, 2,
                    32'h0000_0013, 32'h0002_2000, 3'b100, 6, 32'h0000_0013};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 4'b0011, 3, 0, 0,
                    32'h0, 32'h0002_0040, 3'b000, 6, 32'h0000_0013};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_BABE, 4'b1111, 0, 2, 1,
                    32'h0, 32'h0002_0080, 3'b000, 6, 32'h0000_0013};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_8000, 32'h0, 4'h0, 0, 0, 0,
                    32'hA5A5_5A5A, 32'h0001_8000, 3'b000, 3, 32'hA5A5_5A5A};
        vecs[5] = '{1'b1, 1'b1, 32'hFFFE_0004, 32'h0000_00FF, 4'b1000, 0, 0, 0,
                    32'h0, 32'h0000_0004, 3'b100, 3, 32'hA5A5_5A5A};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 0, 5,
                    32'hCAFE_F00D, 32'h0002_0000, 3'b000, 8, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 2, 2, 0,
                    32'h0, 32'h0002_0010, 3'b000, 5, 32'hCAFE_F00D};

        res       = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        slave_idle();
        repeat (3) @(negedge clk);
        res = 1'b0;
        chk_reset("reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while a write is stalled on AW/W.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0200;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        chk("midrst_pre_valids", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(2'b11));
        res       = 1'b1;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        chk_reset("midrst");
        res = 1'b0;
        run_vec(vecs[0], 100);

`ifdef PICO_BRIDGE_TIMEOUT_EN
        begin
            int cyc = 0;
            int trap_cyc = -1;
            int ready_seen = 0;
            @(negedge clk);
            mem_valid = 1'b1;
            mem_instr = 1'b0;
            mem_addr  = 32'h0000_0300;
            mem_wstrb = 4'h0;
            slave_idle();
            while (trap_cyc < 0 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (mem_ready) ready_seen++;
                if (trap) trap_cyc = cyc;
                m_axi_arready = m_axi_arvalid;
                m_axi_rvalid  = 1'b0;
            end
            chk("wd_trap_cycle", 64'(trap_cyc), 64'(17));
            chk("wd_outputs_idle", 64'({m_axi_rready, m_axi_arvalid, mem_ready}), 64'(0));
            repeat (3) begin
                @(negedge clk);
                if (mem_ready) ready_seen++;
            end
            chk("wd_trap_sticky", 64'(trap), 64'(1));
            chk("wd_no_ready", 64'(ready_seen), 64'(0));
            res       = 1'b1;
            mem_valid = 1'b0;
            slave_idle();
            @(negedge clk);
            res = 1'b0;
            chk("wd_trap_cleared", 64'(trap), 64'(0));
            run_vec(vecs[0], 200);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
